// File: rtl/rs_array.sv
// Reservation station: DEPTH entries wait for CDB wake-up and issue the oldest ready entry.
// Optional macro RS_WAKEUP_BYPASS_EN lets an entry issue in the same cycle the CDB wakes it.
module rs_array #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned DW    = 8,
  parameter int unsigned TAGW  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_disp_valid,
  output logic                         o_disp_ready,
  input  logic [DW-1:0]                i_disp_operand,
  input  logic [DW-1:0]                i_disp_wbs,
  input  logic [DW-1:0]                i_disp_flag,
  input  logic [TAGW-1:0]              i_disp_robid,
  input  logic [NSRC-1:0]              i_disp_srcrdy,
  input  logic [NSRC*TAGW-1:0]         i_disp_srctag,
  input  logic [NSRC*DW-1:0]           i_disp_srcval,
  input  logic                         i_cdb_valid,
  input  logic [TAGW-1:0]              i_cdb_tag,
  input  logic [DW-1:0]                i_cdb_val,
  output logic                         o_iss_valid,
  input  logic                         i_iss_ready,
  output logic [DW-1:0]                o_iss_operand,
  output logic [DW-1:0]                o_iss_wbs,
  output logic [DW-1:0]                o_iss_flag,
  output logic [TAGW-1:0]              o_iss_robid,
  output logic [NSRC*DW-1:0]           o_iss_srcval,
  input  logic                         i_flush,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] r_busy;
  logic [NSRC-1:0]  r_rdy     [DEPTH];
  logic [TAGW-1:0]  r_tag     [DEPTH][NSRC];
  logic [DW-1:0]    r_val     [DEPTH][NSRC];
  logic [DW-1:0]    r_operand [DEPTH];
  logic [DW-1:0]    r_wbs     [DEPTH];
  logic [DW-1:0]    r_flag    [DEPTH];
  logic [TAGW-1:0]  r_robid   [DEPTH];
  // r_age[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0] r_age     [DEPTH];

  logic [NSRC-1:0]  w_hit     [DEPTH];
  logic [NSRC-1:0]  w_src_rdy [DEPTH];
  logic [DW-1:0]    w_src_val [DEPTH][NSRC];
  logic [DEPTH-1:0] w_elig;
  logic [DEPTH-1:0] w_sel;
  logic             w_iss_valid;
  logic             w_iss_fire;
  logic             w_disp_fire;
  logic [IW-1:0]    w_free_idx;
  logic [CW-1:0]    w_count;
  logic [NSRC-1:0]  w_dsrc_rdy;
  logic [DW-1:0]    w_dsrc_val [NSRC];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < NSRC; s++) begin
        w_hit[i][s] = r_busy[i] && i_cdb_valid && !r_rdy[i][s] && (r_tag[i][s] == i_cdb_tag);
`ifdef RS_WAKEUP_BYPASS_EN
        w_src_rdy[i][s] = r_rdy[i][s] | w_hit[i][s];
        w_src_val[i][s] = r_rdy[i][s] ? r_val[i][s] : i_cdb_val;
`else
        w_src_rdy[i][s] = r_rdy[i][s];
        w_src_val[i][s] = r_val[i][s];
`endif
      end
      w_elig[i] = r_busy[i] & (&w_src_rdy[i]);
    end
  end

  // Oldest eligible entry wins: drop any candidate that has an older eligible peer
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = w_elig[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && w_elig[j] && r_age[j][i]) w_sel[i] = 1'b0;
      end
    end
  end

  assign w_iss_valid  = (|w_sel) & ~i_flush;
  assign w_iss_fire   = w_iss_valid & i_iss_ready;
  assign o_iss_valid  = w_iss_valid;
  assign o_full       = (w_count == CW'(DEPTH));
  assign o_empty      = (w_count == '0);
  assign o_count      = w_count;
  assign o_disp_ready = ~o_full;
  assign w_disp_fire  = i_disp_valid & o_disp_ready;

  always_comb begin
    o_iss_operand = '0;
    o_iss_wbs     = '0;
    o_iss_flag    = '0;
    o_iss_robid   = '0;
    o_iss_srcval  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_iss_valid && w_sel[i]) begin
        o_iss_operand = o_iss_operand | r_operand[i];
        o_iss_wbs     = o_iss_wbs | r_wbs[i];
        o_iss_flag    = o_iss_flag | r_flag[i];
        o_iss_robid   = o_iss_robid | r_robid[i];
        for (int s = 0; s < NSRC; s++) begin
          o_iss_srcval[s*DW +: DW] = o_iss_srcval[s*DW +: DW] | w_src_val[i][s];
        end
      end
    end
  end

  always_comb begin
    w_free_idx = '0;
    w_count    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = IW'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + CW'(r_busy[i]);
    end
  end

  // A source broadcast on the CDB in the dispatch cycle is captured as ready
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      w_dsrc_rdy[s] = i_disp_srcrdy[s] |
                      (i_cdb_valid && (i_disp_srctag[s*TAGW +: TAGW] == i_cdb_tag));
      w_dsrc_val[s] = i_disp_srcrdy[s] ? i_disp_srcval[s*DW +: DW] : i_cdb_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rdy[i]     <= '0;
        r_age[i]     <= '0;
        r_operand[i] <= '0;
        r_wbs[i]     <= '0;
        r_flag[i]    <= '0;
        r_robid[i]   <= '0;
        for (int s = 0; s < NSRC; s++) begin
          r_tag[i][s] <= '0;
          r_val[i][s] <= '0;
        end
      end
    end else if (i_flush) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int s = 0; s < NSRC; s++) begin
          if (w_hit[i][s]) begin
            r_rdy[i][s] <= 1'b1;
            r_val[i][s] <= i_cdb_val;
          end
        end
      end
      if (w_iss_fire) r_busy <= r_busy & ~w_sel;
      if (w_disp_fire) begin
        r_busy[w_free_idx]    <= 1'b1;
        r_operand[w_free_idx] <= i_disp_operand;
        r_wbs[w_free_idx]     <= i_disp_wbs;
        r_flag[w_free_idx]    <= i_disp_flag;
        r_robid[w_free_idx]   <= i_disp_robid;
        r_rdy[w_free_idx]     <= w_dsrc_rdy;
        for (int s = 0; s < NSRC; s++) begin
          r_tag[w_free_idx][s] <= i_disp_srctag[s*TAGW +: TAGW];
          r_val[w_free_idx][s] <= w_dsrc_val[s];
        end
        // Newest entry is younger than everything already present
        r_age[w_free_idx] <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (j != int'(w_free_idx)) r_age[j][w_free_idx] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_array.sv
// Self-checking bench for rs_array: directed scenarios plus random traffic against a
// sequence-numbered behavioural model of the station.
module tb_rs_array;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NSRC  = 2;
  localparam int unsigned DW    = 8;
  localparam int unsigned TAGW  = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef RS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic                disp_valid;
  logic                disp_ready;
  logic [DW-1:0]       disp_operand, disp_wbs, disp_flag;
  logic [TAGW-1:0]     disp_robid;
  logic [NSRC-1:0]     disp_srcrdy;
  logic [NSRC*TAGW-1:0] disp_srctag;
  logic [NSRC*DW-1:0]  disp_srcval;
  logic                cdb_valid;
  logic [TAGW-1:0]     cdb_tag;
  logic [DW-1:0]       cdb_val;
  logic                iss_valid;
  logic                iss_ready;
  logic [DW-1:0]       iss_operand, iss_wbs, iss_flag;
  logic [TAGW-1:0]     iss_robid;
  logic [NSRC*DW-1:0]  iss_srcval;
  logic                flush;
  logic [CW-1:0]       count;
  logic                full, empty;

  rs_array #(.DEPTH(DEPTH), .NSRC(NSRC), .DW(DW), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .i_disp_valid(disp_valid), .o_disp_ready(disp_ready),
    .i_disp_operand(disp_operand), .i_disp_wbs(disp_wbs), .i_disp_flag(disp_flag),
    .i_disp_robid(disp_robid), .i_disp_srcrdy(disp_srcrdy), .i_disp_srctag(disp_srctag),
    .i_disp_srcval(disp_srcval),
    .i_cdb_valid(cdb_valid), .i_cdb_tag(cdb_tag), .i_cdb_val(cdb_val),
    .o_iss_valid(iss_valid), .i_iss_ready(iss_ready),
    .o_iss_operand(iss_operand), .o_iss_wbs(iss_wbs), .o_iss_flag(iss_flag),
    .o_iss_robid(iss_robid), .o_iss_srcval(iss_srcval),
    .i_flush(flush), .o_count(count), .o_full(full), .o_empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: each live slot carries a dispatch sequence number; oldest = smallest number
  bit              m_busy [DEPTH];
  bit [NSRC-1:0]   m_rdy  [DEPTH];
  logic [TAGW-1:0] m_tag  [DEPTH][NSRC];
  logic [DW-1:0]   m_val  [DEPTH][NSRC];
  logic [DW-1:0]   m_op [DEPTH], m_wbs [DEPTH], m_flag [DEPTH];
  logic [TAGW-1:0] m_rob [DEPTH];
  int              m_seq [DEPTH];
  int              seq_ctr = 0;
  int              e_sel;
  bit              e_valid;
  int              e_count;

  logic [TAGW-1:0]    iss_rob_q [$];
  logic [NSRC*DW-1:0] iss_sv_q  [$];

  task automatic model_eval();
    bit all_rdy;
    bit r;
    e_sel   = -1;
    e_count = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_busy[i]) begin
        e_count++;
        all_rdy = 1'b1;
        for (int s = 0; s < NSRC; s++) begin
          r = m_rdy[i][s];
          if (BYP && !r && cdb_valid && m_tag[i][s] == cdb_tag) r = 1'b1;
          if (!r) all_rdy = 1'b0;
        end
        if (all_rdy && (e_sel < 0 || m_seq[i] < m_seq[e_sel])) e_sel = i;
      end
    end
    e_valid = (e_sel >= 0) && !flush;
  endtask

  task automatic compare();
    logic [NSRC*DW-1:0] sv;
    logic [TAGW-1:0]    rob;
    logic [DW-1:0]      op, wb, fl;
    sv = '0; rob = '0; op = '0; wb = '0; fl = '0;
    model_eval();
    if (e_valid) begin
      rob = m_rob[e_sel]; op = m_op[e_sel]; wb = m_wbs[e_sel]; fl = m_flag[e_sel];
      for (int s = 0; s < NSRC; s++) sv[s*DW +: DW] = m_rdy[e_sel][s] ? m_val[e_sel][s] : cdb_val;
    end
    check("iss_valid", iss_valid, e_valid);
    check("iss_robid", iss_robid, rob);
    check("iss_operand", iss_operand, op);
    check("iss_wbs", iss_wbs, wb);
    check("iss_flag", iss_flag, fl);
    check("iss_srcval", iss_srcval, sv);
    check("count", count, e_count);
    check("full", full, e_count == DEPTH);
    check("empty", empty, e_count == 0);
    check("disp_ready", disp_ready, e_count != DEPTH);
    if (iss_valid && iss_ready) begin
      iss_rob_q.push_back(iss_robid);
      iss_sv_q.push_back(iss_srcval);
    end
  endtask

  task automatic model_next();
    int fr;
    fr = -1;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      seq_ctr = 0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    end else begin
      for (int i = DEPTH - 1; i >= 0; i--) if (!m_busy[i]) fr = i;
      for (int i = 0; i < DEPTH; i++)
        for (int s = 0; s < NSRC; s++)
          if (m_busy[i] && !m_rdy[i][s] && cdb_valid && m_tag[i][s] == cdb_tag) begin
            m_rdy[i][s] = 1'b1;
            m_val[i][s] = cdb_val;
          end
      if (e_valid && iss_ready) m_busy[e_sel] = 1'b0;
      if (disp_valid && e_count < DEPTH) begin
        m_busy[fr] = 1'b1;
        m_seq[fr]  = seq_ctr++;
        m_op[fr] = disp_operand; m_wbs[fr] = disp_wbs; m_flag[fr] = disp_flag;
        m_rob[fr] = disp_robid;
        for (int s = 0; s < NSRC; s++) begin
          m_tag[fr][s] = disp_srctag[s*TAGW +: TAGW];
          m_rdy[fr][s] = disp_srcrdy[s] ||
                         (cdb_valid && disp_srctag[s*TAGW +: TAGW] == cdb_tag);
          m_val[fr][s] = disp_srcrdy[s] ? disp_srcval[s*DW +: DW] : cdb_val;
        end
      end
    end
  endtask

  // Inputs are set just after a falling edge; compare, advance the model, wait a cycle
  task automatic step();
    #1;
    compare();
    model_next();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0; cdb_valid = 1'b0;
    cdb_tag = '0; cdb_val = '0; disp_operand = '0; disp_wbs = '0; disp_flag = '0;
    disp_robid = '0; disp_srcrdy = '0; disp_srctag = '0; disp_srcval = '0;
  endtask

  task automatic disp(input logic [TAGW-1:0] rob, input logic [NSRC-1:0] rdy,
                      input logic [NSRC*TAGW-1:0] tags, input logic [NSRC*DW-1:0] vals);
    disp_valid   = 1'b1;
    disp_robid   = rob;
    disp_srcrdy  = rdy;
    disp_srctag  = tags;
    disp_srcval  = vals;
    disp_operand = DW'($urandom);
    disp_wbs     = DW'($urandom);
    disp_flag    = DW'($urandom);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    #1 model_next();
    @(negedge clk);
    idle();
    step();  // reset state

    // Single ready instruction issues the next cycle
    iss_rob_q.delete(); iss_sv_q.delete();
    disp(4'd3, 2'b11, 8'h00, 16'h2211); iss_ready = 1'b1;
    step();
    idle(); iss_ready = 1'b1;
    step();
    step();
    check("t030_n", iss_rob_q.size(), 1);
    if (iss_rob_q.size() >= 1) begin
      check("t030_rob", iss_rob_q[0], 3);
      check("t030_sv", iss_sv_q[0], 16'h2211);
    end
    check("t030_cnt", count, 0);

    // Fill with four waiters, wake all with one broadcast, drain in order
    iss_rob_q.delete(); iss_sv_q.delete();
    for (int k = 1; k <= 4; k++) begin
      idle();
      disp(TAGW'(k), 2'b10, 8'h05, 16'h3300);
      step();
    end
    check("t031_full", full, 1);
    check("t031_drdy", disp_ready, 0);
    idle(); disp(4'd15, 2'b11, 8'h00, 16'h0101);  // refused while full
    step();
    idle(); cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_val = 8'h7E; iss_ready = 1'b1;
    step();
    idle(); iss_ready = 1'b1;
    repeat (5) step();
    check("t031_n", iss_rob_q.size(), 4);
    if (iss_rob_q.size() >= 4)
      for (int k = 0; k < 4; k++) begin
        check("t031_order", iss_rob_q[k], k + 1);
        check("t031_sv", iss_sv_q[k], 16'h337E);
      end

    // Dispatch-cycle CDB capture
    iss_rob_q.delete(); iss_sv_q.delete();
    idle(); disp(4'd6, 2'b10, 8'h09, 16'h4400);
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_val = 8'h40;
    step();
    idle(); iss_ready = 1'b1;
    step(); step();
    check("t032_n", iss_rob_q.size(), 1);
    if (iss_rob_q.size() >= 1) begin
      check("t032_rob", iss_rob_q[0], 6);
      check("t032_sv", iss_sv_q[0], 16'h4440);
    end

    // Flush beats dispatch and issue
    iss_rob_q.delete(); iss_sv_q.delete();
    for (int k = 7; k <= 9; k++) begin
      idle(); disp(TAGW'(k), 2'b11, 8'h00, 16'h1234); step();
    end
    check("t033_cnt3", count, 3);
    idle(); disp(4'd10, 2'b11, 8'h00, 16'h5678); flush = 1'b1; iss_ready = 1'b1;
    step();
    idle();
    check("t033_cnt", count, 0);
    check("t033_empty", empty, 1);
    check("t033_n", iss_rob_q.size(), 0);
    step();

    // Wake-up-to-issue latency
    iss_rob_q.delete(); iss_sv_q.delete();
    idle(); disp(4'd11, 2'b01, 8'h20, 16'h0005);
    step();
    idle(); step();
    cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_val = 8'h55;
    #1 check("t034_wake", iss_valid, BYP);
    step();
    idle(); iss_ready = 1'b1;
    step(); step();
    check("t034_n", iss_rob_q.size(), 1);
    if (iss_rob_q.size() >= 1) check("t034_sv", iss_sv_q[0], 16'h5505);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) < 6)
        disp(TAGW'($urandom), NSRC'($urandom),
             {TAGW'($urandom_range(0, 7)), TAGW'($urandom_range(0, 7))}, 16'($urandom));
      iss_ready = ($urandom_range(0, 9) < 6);
      cdb_valid = $urandom_range(0, 1);
      cdb_tag   = TAGW'($urandom_range(0, 7));
      cdb_val   = DW'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_array.md
RS_ARRAY -- requirements
Module: rs_array

Interface
REQ-001 The module SHALL expose parameter DEPTH, default 4, number of station entries (power of two, 2..16).
REQ-002 The module SHALL expose parameter NSRC, default 2, source operands per entry (1..3).
REQ-003 The module SHALL expose parameter DW, default 8, data width of operand, wbs, flag and source values.
REQ-004 The module SHALL expose parameter TAGW, default 4, width of ROB id and CDB tag.
REQ-005 Port clk, input, 1, clock; all state updates on rising edge.
REQ-006 Port rst, input, 1, reset: synchronous, active-high.
REQ-007 Ports disp_valid input 1 and disp_ready output 1 form the dispatch handshake; disp_ready = !full.
REQ-008 Ports disp_operand, disp_wbs, disp_flag, input DW each, and disp_robid, input TAGW, carry the instruction payload.
REQ-009 Ports disp_srcrdy input NSRC, disp_srctag input NSRC x TAGW, disp_srcval input NSRC x DW give per-source ready bit, producer tag and value.
REQ-010 Ports cdb_valid input 1, cdb_tag input TAGW, cdb_val input DW form the broadcast result bus.
REQ-011 Ports iss_valid output 1 and iss_ready input 1 form the issue handshake to the functional unit.
REQ-012 Ports iss_operand, iss_wbs, iss_flag output DW, iss_robid output TAGW, iss_srcval output NSRC x DW carry the issued entry.
REQ-013 Port flush, input, 1, discards every entry.
REQ-014 Ports count output clog2(DEPTH+1), full output 1, empty output 1 report occupancy.

Function
REQ-015 Each entry SHALL be in exactly one state: FREE, WAIT (any source not ready), READY (all sources ready).
REQ-016 Dispatch fire (disp_valid & disp_ready) SHALL write the lowest-index FREE entry; state WAIT or READY per its source ready bits after capture.
REQ-017 A dispatched source with srcrdy=0 whose tag equals cdb_tag while cdb_valid in the same cycle SHALL be captured as ready with cdb_val.
REQ-018 Every WAIT entry source with ready=0 and tag==cdb_tag under cdb_valid SHALL capture cdb_val and set ready at that edge; multiple matching entries/sources all capture.
REQ-019 iss_valid SHALL be asserted whenever any entry is READY and flush=0; the selected entry is the oldest READY entry by dispatch order (age matrix, no ties).
REQ-020 While iss_valid=0, all iss_* data outputs SHALL be zero.
REQ-021 Issue fire (iss_valid & iss_ready) SHALL return the selected entry to FREE at that edge; iss_valid held without iss_ready SHALL keep the same entry selected unless an older entry becomes READY.
REQ-022 Same-cycle dispatch and issue fire SHALL both take effect; count unchanged; a full station does not accept dispatch in the cycle it issues.
REQ-023 Latency: instruction dispatched with all sources ready at edge N SHALL present iss_valid in cycle N+1.
REQ-024 flush SHALL have priority: at that edge all entries become FREE, dispatch and issue in that cycle are dropped, count becomes 0.
REQ-025 count SHALL equal non-FREE entries; full = (count==DEPTH); empty = (count==0).

Reset
REQ-026 rst SHALL free all entries and clear ages, source values and tags to zero at the next edge, overriding flush, dispatch, issue and CDB capture.
REQ-027 After reset, outputs SHALL be iss_valid=0, iss_* data 0, count=0, empty=1, full=0, disp_ready=1.

Configuration
REQ-028 With macro RS_WAKEUP_BYPASS_EN defined, a WAIT entry whose last missing source matches the CDB in cycle N SHALL be issue-eligible in cycle N, issuing cdb_val as that source (wake-up-to-issue latency 0).
REQ-029 Without RS_WAKEUP_BYPASS_EN, such an entry SHALL become READY at edge N and be issue-eligible no earlier than cycle N+1.

Verification
REQ-030 Reset, then dispatch robid=3 with both sources ready (vals 0x11,0x22), iss_ready=1 -> next cycle iss_valid=1, iss_robid=3, iss_srcval={0x22,0x11}, count returns 0.
REQ-031 Dispatch robid 1,2,3,4 with src tag 5 unready, iss_ready=0 -> full=1, disp_ready=0; then CDB tag 5 val 0x7E -> all four READY, issued in order 1,2,3,4 with iss_ready=1.
REQ-032 Dispatch robid=6 waiting on tag 9 while cdb_valid with tag 9 val 0x40 the same cycle -> captured; iss_valid next cycle with srcval 0x40.
REQ-033 Station holds 3 entries, assert flush together with disp_valid and iss_ready -> nothing issued, count=0, empty=1 next cycle.
REQ-034 Entry waiting on tag 2, CDB tag 2 val 0x55 in cycle N -> iss_valid in cycle N with RS_WAKEUP_BYPASS_EN, in N+1 without; iss srcval 0x55 both.
